// File: rtl/dcp_run_pkg.sv
// Shared definitions for the CPU run/step sequencer: command opcodes,
// stop causes and the sequencer state enumeration.
package dcp_run_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_STEP       = 3'd0;
    localparam logic [2:0] OP_GO         = 3'd1;
    localparam logic [2:0] OP_HALT       = 3'd2;
    localparam logic [2:0] OP_BP_SET     = 3'd3;
    localparam logic [2:0] OP_BP_CLR     = 3'd4;
    localparam logic [2:0] OP_BP_CLR_ALL = 3'd5;

    localparam logic [1:0] CAUSE_CFG  = 2'd0;
    localparam logic [1:0] CAUSE_BP   = 2'd1;
    localparam logic [1:0] CAUSE_HALT = 2'd2;
    localparam logic [1:0] CAUSE_PC   = 2'd3;

endpackage

// File: rtl/bp_match.sv
// Breakpoint table (address + enable per slot) and a priority comparator
// against the current PC; the lowest matching slot wins.
module bp_match #(
    parameter int NUM_BP = 4,
    parameter int IDX_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic             clr,
    input  logic             clr_all,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_addr,
    input  logic [31:0]      pc,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    logic [NUM_BP-1:0] en;
    logic [31:0]       addr [NUM_BP];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en <= '0;
        end else begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (clr_all)
                    en[i] <= 1'b0;
                else if (set && wr_idx == IDX_W'(i))
                    en[i] <= 1'b1;
                else if (clr && wr_idx == IDX_W'(i))
                    en[i] <= 1'b0;
            end
        end
    end

    // Addresses are only meaningful while enabled, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BP; i++)
            if (set && wr_idx == IDX_W'(i))
                addr[i] <= wr_addr;
    end

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (en[i] && pc == addr[i]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctl.sv
// Run/step sequencer for the CPU under debug: STEP/GO/HALT/breakpoint commands,
// CPU clock enable and stop reporting. Breakpoints exist only with CPU_RUN_BP_EN.
module cpu_run_ctl
    import dcp_run_pkg::*;
#(
    parameter int NUM_BP = 4,
    parameter int IDX_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_vld,
    output logic             cmd_rdy,
    input  logic [2:0]       cmd_op,
    input  logic [31:0]      cmd_arg,
    input  logic [IDX_W-1:0] cmd_idx,
    input  logic [31:0]      PC,
    input  logic             pc_chk,
    output logic             cpu_ce,
    output logic             running,
    output logic             done,
    output logic [1:0]       stop_cause,
    output logic [IDX_W-1:0] bp_hit_idx
);

    state_t           state, state_nxt;
    logic [31:0]      cnt;
    logic             first;
    logic [1:0]       cause_nxt;
    logic             bp_stop;
    logic             bp_hit;
    logic [IDX_W-1:0] bp_idx;
    logic             idle_acc;

    assign idle_acc = (state == S_IDLE) && cmd_vld;

`ifdef CPU_RUN_BP_EN
    bp_match #(.NUM_BP(NUM_BP), .IDX_W(IDX_W)) u_bp (
        .clk     (clk),
        .rst     (rst),
        .set     (idle_acc && cmd_op == OP_BP_SET),
        .clr     (idle_acc && cmd_op == OP_BP_CLR),
        .clr_all (idle_acc && cmd_op == OP_BP_CLR_ALL),
        .wr_idx  (cmd_idx),
        .wr_addr (cmd_arg),
        .pc      (PC),
        .hit     (bp_hit),
        .idx     (bp_idx)
    );
`else
    logic unused_bp;
    assign unused_bp = ^{cmd_idx, PC};
    assign bp_hit    = 1'b0;
    assign bp_idx    = '0;
`endif

    always_comb begin
        state_nxt = state;
        cause_nxt = stop_cause;
        cmd_rdy   = 1'b0;
        cpu_ce    = 1'b0;
        done      = 1'b0;
        bp_stop   = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_rdy = 1'b1;
                if (cmd_vld) begin
                    state_nxt = S_DONE;
                    cause_nxt = CAUSE_CFG;
                    case (cmd_op)
                        OP_STEP: state_nxt = S_STEP;
                        OP_GO:   state_nxt = S_RUN;
                        OP_HALT: cause_nxt = CAUSE_HALT;
                        default: ;
                    endcase
                end
            end
            S_STEP: begin
                cpu_ce = (cnt != 32'd0);
                if (cnt <= 32'd1) begin
                    state_nxt = S_DONE;
                    cause_nxt = CAUSE_CFG;
                end
            end
            S_RUN: begin
                cmd_rdy   = 1'b1;
                state_nxt = S_DONE;
                if (cmd_vld && cmd_op == OP_HALT) begin
                    cause_nxt = CAUSE_HALT;
                end else if (pc_chk && !first) begin
                    cause_nxt = CAUSE_PC;
                end else if (bp_hit && !first) begin
                    cause_nxt = CAUSE_BP;
                    bp_stop   = 1'b1;
                end else begin
                    state_nxt = S_RUN;
                    cpu_ce    = 1'b1;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign running = (state == S_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            first      <= 1'b0;
            stop_cause <= CAUSE_CFG;
            bp_hit_idx <= '0;
        end else begin
            state      <= state_nxt;
            stop_cause <= cause_nxt;
            if (bp_stop)
                bp_hit_idx <= bp_idx;
            // A zero step count still advances the CPU by one cycle.
            if (idle_acc && cmd_op == OP_STEP)
                cnt <= (cmd_arg == 32'd0) ? 32'd1 : cmd_arg;
            else if (state == S_STEP && cnt != 32'd0)
                cnt <= cnt - 32'd1;
            if (idle_acc && cmd_op == OP_GO)
                first <= 1'b1;
            else if (running && cpu_ce)
                first <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctl.sv
// Self-checking bench for cpu_run_ctl: directed test-plan scenarios plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_cpu_run_ctl;

    localparam int NUM_BP = 4;
    localparam int IDX_W  = 2;
`ifdef CPU_RUN_BP_EN
    localparam bit BP_ON = 1'b1;
`else
    localparam bit BP_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_vld;
    logic             cmd_rdy;
    logic [2:0]       cmd_op;
    logic [31:0]      cmd_arg;
    logic [IDX_W-1:0] cmd_idx;
    logic [31:0]      PC;
    logic             pc_chk;
    logic             cpu_ce;
    logic             running;
    logic             done;
    logic [1:0]       stop_cause;
    logic [IDX_W-1:0] bp_hit_idx;

    cpu_run_ctl #(.NUM_BP(NUM_BP), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_vld    (cmd_vld),
        .cmd_rdy    (cmd_rdy),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .cmd_idx    (cmd_idx),
        .PC         (PC),
        .pc_chk     (pc_chk),
        .cpu_ce     (cpu_ce),
        .running    (running),
        .done       (done),
        .stop_cause (stop_cause),
        .bp_hit_idx (bp_hit_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 waiting, 1 stepping, 2 free-running, 3 reporting.
    int               m_mode;
    longint           m_left;
    bit               m_first;
    bit [1:0]         m_cause;
    bit [IDX_W-1:0]   m_idx;
    bit               m_en   [NUM_BP];
    bit [31:0]        m_addr [NUM_BP];

    function automatic int m_hit_slot();
        for (int i = 0; i < NUM_BP; i++)
            if (BP_ON && m_en[i] && m_addr[i] == PC) return i;
        return -1;
    endfunction

    function automatic bit m_halt();
        return cmd_vld && cmd_op == 3'd2;
    endfunction

    function automatic bit m_ce();
        if (m_mode == 1) return m_left > 0;
        if (m_mode == 2) return !m_halt() && (m_first || (!pc_chk && m_hit_slot() < 0));
        return 1'b0;
    endfunction

    task automatic m_reset();
        m_mode = 0; m_left = 0; m_first = 0; m_cause = 0; m_idx = '0;
        for (int i = 0; i < NUM_BP; i++) m_en[i] = 0;
    endtask

    task automatic m_step();
        int slot;
        case (m_mode)
            0: if (cmd_vld) begin
                m_mode  = 3;
                m_cause = 0;
                case (cmd_op)
                    3'd0: begin m_left = (cmd_arg == 0) ? 1 : longint'(cmd_arg); m_mode = 1; end
                    3'd1: begin m_first = 1; m_mode = 2; end
                    3'd2: m_cause = 2;
                    3'd3: if (BP_ON && int'(cmd_idx) < NUM_BP) begin
                        m_en[cmd_idx] = 1; m_addr[cmd_idx] = cmd_arg;
                    end
                    3'd4: if (BP_ON && int'(cmd_idx) < NUM_BP) m_en[cmd_idx] = 0;
                    3'd5: for (int i = 0; i < NUM_BP; i++) m_en[i] = 0;
                    default: ;
                endcase
            end
            1: begin
                m_left--;
                if (m_left == 0) begin m_mode = 3; m_cause = 0; end
            end
            2: begin
                slot = m_hit_slot();
                if (m_halt())                    begin m_mode = 3; m_cause = 2; end
                else if (pc_chk && !m_first)     begin m_mode = 3; m_cause = 3; end
                else if (slot >= 0 && !m_first)  begin m_mode = 3; m_cause = 1; m_idx = IDX_W'(slot); end
                else m_first = 0;
            end
            default: m_mode = 0;
        endcase
    endtask

    int ce_cnt, done_cnt;
    bit saw_done, pc_ramp;

    // One clock: compare outputs after inputs settle, advance model on the edge.
    task automatic tick();
        logic [8:0] expv, actv;
        #1;
        expv = {(m_mode == 0 || m_mode == 2), m_ce(), (m_mode == 2), (m_mode == 3), m_cause, m_idx};
        actv = {cmd_rdy, cpu_ce, running, done, stop_cause, bp_hit_idx};
        check("outputs{rdy,ce,run,done,cause,idx}", 64'(actv), 64'(expv));
        if (cpu_ce) ce_cnt++;
        if (done) begin done_cnt++; saw_done = 1; end
        @(posedge clk);
        if (rst) m_reset(); else m_step();
        @(negedge clk);
        if (pc_ramp) PC = PC + 32'd4;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] arg, input logic [IDX_W-1:0] idx);
        cmd_vld = 1'b1; cmd_op = op; cmd_arg = arg; cmd_idx = idx;
        tick();
        cmd_vld = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok, output int n);
        saw_done = 0;
        n = 0;
        while (!saw_done && n < bound) begin
            tick();
            n++;
        end
        ok = saw_done;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_reset();
        #1;
        check("async reset ce", 64'(cpu_ce), 64'd0);
        check("async reset running", 64'(running), 64'd0);
        check("async reset done", 64'(done), 64'd0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bit ok;
        int n;
        rst = 1'b1; cmd_vld = 0; cmd_op = 0; cmd_arg = 0; cmd_idx = 0; PC = 0; pc_chk = 0;
        pc_ramp = 0; ce_cnt = 0; done_cnt = 0; saw_done = 0;
        m_reset();
        @(negedge clk);
        do_reset();
        check("reset stop_cause", 64'(stop_cause), 64'd0);
        check("reset bp_hit_idx", 64'(bp_hit_idx), 64'd0);
        check("reset cmd_rdy", 64'(cmd_rdy), 64'd1);

        // STEP 3: ce in the three cycles after acceptance, done in the fourth
        ce_cnt = 0;
        send(3'd0, 32'd3, '0);
        wait_done(10, ok, n);
        check("step3 done", 64'(ok), 64'd1);
        check("step3 latency", 64'(n), 64'd4);
        check("step3 ce cycles", 64'(ce_cnt), 64'd3);
        check("step3 cause", 64'(stop_cause), 64'd0);

        // STEP 0 behaves as STEP 1
        ce_cnt = 0;
        send(3'd0, 32'd0, '0);
        wait_done(10, ok, n);
        check("step0 ce cycles", 64'(ce_cnt), 64'd1);

        // Breakpoint at slot 1, run with a ramping PC
        send(3'd3, 32'h10, 2'd1);
        wait_done(3, ok, n);
        check("bp_set done", 64'(ok), 64'd1);
        check("bp_set cause", 64'(stop_cause), 64'd0);
        PC = 0; pc_ramp = 1; ce_cnt = 0;
        send(3'd1, 32'd0, '0);
        wait_done(12, ok, n);
        pc_ramp = 0;
        if (!ok) begin
            send(3'd2, 32'd0, '0);
            wait_done(3, ok, n);
        end
        check("go ramp stopped", 64'(ok), 64'd1);
        check("go ramp ce cycles", 64'(ce_cnt), BP_ON ? 64'd3 : 64'd12);
        check("go ramp cause", 64'(stop_cause), BP_ON ? 64'd1 : 64'd2);
        check("go ramp bp_hit_idx", 64'(bp_hit_idx), BP_ON ? 64'd1 : 64'd0);

        // GO while parked on the breakpoint advances, then HALT
        PC = 32'h10; ce_cnt = 0;
        send(3'd1, 32'd0, '0);
        tick();
        check("go off bp first ce", 64'(ce_cnt), 64'd1);
        PC = 32'h14;
        repeat (3) tick();
        check("go continues ce", 64'(ce_cnt), 64'd4);
        check("go continues running", 64'(running), 64'd1);
        send(3'd2, 32'd0, '0);
        check("halt cycle ce low", 64'(ce_cnt), 64'd4);
        wait_done(3, ok, n);
        check("halt done", 64'(ok), 64'd1);
        check("halt cause", 64'(stop_cause), 64'd2);
        repeat (2) tick();
        check("no ce after halt", 64'(ce_cnt), 64'd4);

        // pc_chk outranks a breakpoint hit
        PC = 32'h10; pc_chk = 1; ce_cnt = 0;
        send(3'd1, 32'd0, '0);
        wait_done(5, ok, n);
        pc_chk = 0;
        check("pcchk done", 64'(ok), 64'd1);
        check("pcchk cause", 64'(stop_cause), 64'd3);
        check("pcchk ce cycles", 64'(ce_cnt), 64'd1);

        // After BP_CLR_ALL, PC 0x10 no longer stops the run
        send(3'd5, 32'd0, '0);
        wait_done(3, ok, n);
        PC = 32'h10; ce_cnt = 0; done_cnt = 0;
        send(3'd1, 32'd0, '0);
        repeat (4) tick();
        check("clr_all no stop", 64'(done_cnt), 64'd0);
        check("clr_all ce cycles", 64'(ce_cnt), 64'd4);
        send(3'd2, 32'd0, '0);
        wait_done(3, ok, n);
        check("clr_all halt cause", 64'(stop_cause), 64'd2);

        // Reset in the middle of a long STEP
        send(3'd0, 32'd100, '0);
        repeat (5) tick();
        check("mid-step ce", 64'(cpu_ce), 64'd1);
        done_cnt = 0;
        do_reset();
        repeat (5) tick();
        check("no done after reset", 64'(done_cnt), 64'd0);
        check("idle after reset", 64'(cmd_rdy), 64'd1);

        // Randomized phase against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(599) == 0) begin
                do_reset();
            end else begin
                cmd_vld = ($urandom_range(3) == 0);
                cmd_op  = 3'($urandom_range(7));
                cmd_idx = IDX_W'($urandom);
                cmd_arg = (cmd_op == 3'd0) ? 32'($urandom_range(5)) : 32'($urandom_range(7) * 4);
                PC      = 32'($urandom_range(7) * 4);
                pc_chk  = ($urandom_range(15) == 0);
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
